rst_sequencer: RTL and testbench

Staged reset release sequencer that sits directly downstream of the button reset handler. It consumes the synchronised, active-high system reset and turns it into two registered domain resets. Peripherals leave reset first and the CPU core follows a fixed number of cycles later. It also lets software request a full re-sequence through a one-cycle request pulse, and it records what caused the last reset.

---
 rtl/rst_sequencer_if.sv | 28 ++
 rtl/rst_sequencer.sv | 118 +++++++++++
 tb/tb_rst_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// Purpose: groups the software request and the staged reset outputs of rst_sequencer.
// Latency: none, wires only.
// Backpressure: none; the request is a single-cycle pulse with no acknowledge.
interface rst_sequencer_if;
  logic swrst_req_i;
  logic rst_periph_o;
  logic rst_cpu_o;
  logic rst_done_o;
  logic rst_cause_o;

  // Sequencer side: takes the request, drives the domain resets and status.
  modport master (
    input  swrst_req_i,
    output rst_periph_o,
    output rst_cpu_o,
    output rst_done_o,
    output rst_cause_o
  );

  // Consumer side: issues the request, observes the resets and status.
  modport slave (
    output swrst_req_i,
    input  rst_periph_o,
    input  rst_cpu_o,
    input  rst_done_o,
    input  rst_cause_o
  );
endinterface

// File: rtl/rst_sequencer.sv
// Purpose: staged reset release; peripherals leave reset first, the CPU follows STAGGER_CYCLES later.
// Latency: rst_done high HOLD_CYCLES+STAGGER_CYCLES-1 edges after the first edge with rst_i low.
// Backpressure: none; a software request outside RUN is dropped, not queued.
module rst_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rst_sequencer_if.master bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          periph_q, periph_d;
  logic          cpu_q, cpu_d;
  logic          done_q, done_d;
  logic          cause_q, cause_d;

  // State, counter and every output live in flops; rst_i forces the HOLD start point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      done_q   <= 1'b0;
      cause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
    end
  end

  // Next state and next registered outputs; the counter is cleared on every transition so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    cpu_d    = cpu_q;
    done_d   = done_q;
    cause_d  = cause_q;

    case (state_q)
      HOLD: begin
        periph_d = 1'b1;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          periph_d = 1'b0;
          state_d  = STAGGER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STAGGER: begin
        periph_d = 1'b0;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
        if (cnt_q == STAGGER_LAST) begin
          cnt_d   = '0;
          cpu_d   = 1'b0;
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RUN: begin
        periph_d = 1'b0;
        cpu_d    = 1'b0;
        done_d   = 1'b1;
        // Only honoured here; a request held high re-triggers only once RUN is reached again.
        if (bus.swrst_req_i) begin
          periph_d = 1'b1;
          cpu_d    = 1'b1;
          done_d   = 1'b0;
          cause_d  = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD;
        end
      end

      default: begin
        state_d  = HOLD;
        cnt_d    = '0;
        periph_d = 1'b1;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
      end
    endcase
  end

  assign bus.rst_periph_o = periph_q;
  assign bus.rst_cpu_o    = cpu_q;
  assign bus.rst_done_o   = done_q;
  assign bus.rst_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Purpose: self-checking bench for rst_sequencer at 4/3 and 1/1 hold/stagger settings.
// Latency: checks every edge, 1 time unit after the rising edge.
// Backpressure: not applicable; inputs are driven freely.
module tb_rst_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rst_sequencer_if ifa ();
  rst_sequencer_if ifb ();

  rst_sequencer #(.HOLD_CYCLES(4), .STAGGER_CYCLES(3)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.master)
  );

  rst_sequencer #(.HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.master)
  );

  int n_total = 0;
  int n_pass  = 0;
  int edge_n  = 0;

  // Reference model: each sequence is described by the edge index where it starts
  // (E0, or Es+1); outputs follow from the elapsed edge count.
  int m_h[2]     = '{4, 1};
  int m_s[2]     = '{3, 1};
  int m_start[2] = '{0, 0};
  bit m_p[2]     = '{1'b1, 1'b1};
  bit m_c[2]     = '{1'b1, 1'b1};
  bit m_d[2]     = '{1'b0, 1'b0};
  bit m_cause[2] = '{1'b0, 1'b0};

  typedef struct {
    bit r;
    bit s;
    bit ap, ac, ad, acause;
    bit bp, bc, bd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_n);
  endtask

  task automatic model_edge(input int i, input bit r, input bit s);
    int k;
    if (r) begin
      m_start[i] = edge_n + 1;
      m_cause[i] = 1'b0;
      m_p[i] = 1'b1; m_c[i] = 1'b1; m_d[i] = 1'b0;
    end else if (m_d[i] && s) begin
      m_start[i] = edge_n + 1;
      m_cause[i] = 1'b1;
      m_p[i] = 1'b1; m_c[i] = 1'b1; m_d[i] = 1'b0;
    end else begin
      k = edge_n - m_start[i];
      m_p[i] = (k < m_h[i] - 1);
      m_c[i] = (k < m_h[i] + m_s[i] - 1);
      m_d[i] = !m_c[i];
    end
  endtask

  task automatic cycle(input bit r, input bit s);
    rst = r;
    ifa.swrst_req_i = s;
    ifb.swrst_req_i = s;
    @(posedge clk);
    edge_n++;
    model_edge(0, r, s);
    model_edge(1, r, s);
    #1;
    check("a_periph", ifa.rst_periph_o, m_p[0]);
    check("a_cpu",    ifa.rst_cpu_o,    m_c[0]);
    check("a_done",   ifa.rst_done_o,   m_d[0]);
    check("a_cause",  ifa.rst_cause_o,  m_cause[0]);
    check("a_order",  ifa.rst_cpu_o | ~ifa.rst_periph_o, 1'b1);
    check("b_periph", ifb.rst_periph_o, m_p[1]);
    check("b_cpu",    ifb.rst_cpu_o,    m_c[1]);
    check("b_done",   ifb.rst_done_o,   m_d[1]);
    check("b_cause",  ifb.rst_cause_o,  m_cause[1]);
    check("b_order",  ifb.rst_cpu_o | ~ifb.rst_periph_o, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    ifa.swrst_req_i = 1'b0;
    ifb.swrst_req_i = 1'b0;

    // Power-on then a software reset: {r, s, A periph/cpu/done/cause, B periph/cpu/done}.
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 1, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 1, 0});  // E0
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 1});  // E0+1
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 1});  // E0+2
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1});  // E0+3
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1});  // E0+4
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1});  // E0+5
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 1});  // E0+6
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 1});  // E0+7
    tbl.push_back('{0, 1, 1, 1, 0, 1, 1, 1, 0});  // Es
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 1, 0});  // Es+1
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 1});  // Es+2
    tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 1});  // Es+3
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 1});  // Es+4
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 1});  // Es+5
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 1});  // Es+6
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 1});  // Es+7
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 1});  // Es+8

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].s);
      check("tbl_a_periph", ifa.rst_periph_o, tbl[i].ap);
      check("tbl_a_cpu",    ifa.rst_cpu_o,    tbl[i].ac);
      check("tbl_a_done",   ifa.rst_done_o,   tbl[i].ad);
      check("tbl_a_cause",  ifa.rst_cause_o,  tbl[i].acause);
      check("tbl_b_periph", ifb.rst_periph_o, tbl[i].bp);
      check("tbl_b_cpu",    ifb.rst_cpu_o,    tbl[i].bc);
      check("tbl_b_done",   ifb.rst_done_o,   tbl[i].bd);
    end

    // rst_i reasserted mid-STAGGER, then a full restart from E1.
    cycle(1, 0);
    for (int j = 0; j < 5; j++) cycle(0, 0);
    cycle(1, 0);
    check("midstag_periph", ifa.rst_periph_o, 1'b1);
    check("midstag_cause",  ifa.rst_cause_o,  1'b0);
    for (int j = 0; j < 8; j++) begin
      cycle(0, 0);
      if (j == 2) check("e1_periph_held", ifa.rst_periph_o, 1'b1);
      if (j == 3) check("e1_periph_fall", ifa.rst_periph_o, 1'b0);
      if (j == 5) check("e1_done_low",    ifa.rst_done_o,   1'b0);
      if (j == 6) check("e1_done_rise",   ifa.rst_done_o,   1'b1);
    end

    // Request pulsed during HOLD is dropped.
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 1);
    for (int j = 0; j < 6; j++) cycle(0, 0);
    check("holdreq_done",  ifa.rst_done_o,  1'b1);
    check("holdreq_cause", ifa.rst_cause_o, 1'b0);

    // Software trigger first so the cause bit is 1, then rst_i and request together.
    cycle(0, 1);
    for (int j = 0; j < 8; j++) cycle(0, 0);
    check("sw_cause_set", ifa.rst_cause_o, 1'b1);
    cycle(1, 1);
    check("simul_cause", ifa.rst_cause_o, 1'b0);
    for (int j = 0; j < 8; j++) cycle(0, 0);
    check("simul_done",  ifa.rst_done_o,  1'b1);

    // Request held high across a whole sequence.
    for (int j = 0; j < 12; j++) cycle(0, 1);
    for (int j = 0; j < 10; j++) cycle(0, 0);

    // Randomised traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
